// File: rtl/melody_pkg.sv
// Shared types and helpers for the melody playback controller: state encoding,
// note-code decoding and the tone divider table.
package melody_pkg;

    localparam int unsigned MAX_NOTES  = 8;
    localparam int unsigned REF_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        StIdle,
        StNote,
        StGap,
        StDone
    } state_e;

    // Half-period in clock cycles for a note code; the table is exact at 50 MHz and
    // scaled linearly for other clocks, never below one cycle for a real tone.
    function automatic logic [16:0] tone_half_period(input logic [3:0] code,
                                                     input int unsigned clk_hz = REF_CLK_HZ);
        longint unsigned base;
        longint unsigned scaled;
        case (code)
            4'd1:    base = 95556;
            4'd2:    base = 85131;
            4'd3:    base = 75843;
            4'd4:    base = 71586;
            4'd5:    base = 63776;
            4'd6:    base = 56818;
            4'd7:    base = 50619;
            4'd8:    base = 47778;
            default: base = 0;
        endcase
        scaled = (base * 64'(clk_hz)) / 64'(REF_CLK_HZ);
        if (base != 0 && scaled == 0) scaled = 1;
        if (scaled > 64'd131071) scaled = 64'd131071;
        return 17'(scaled);
    endfunction

    function automatic logic is_tone(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd8);
    endfunction

    function automatic logic [3:0] clamp_length(input logic [3:0] len);
        return (len > 4'(MAX_NOTES)) ? 4'(MAX_NOTES) : len;
    endfunction

    function automatic logic [3:0] note_code(input logic [31:0] pat, input logic [2:0] idx);
        return pat[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave generator: a half-period divider and toggle flop, restarted low on
// every note entry and held silent for rest codes.
module tone_gen
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [3:0] code,
    output logic       piezo
);

    localparam logic [16:0] HALF_TAB [8] = '{
        tone_half_period(4'd1, CLK_HZ), tone_half_period(4'd2, CLK_HZ),
        tone_half_period(4'd3, CLK_HZ), tone_half_period(4'd4, CLK_HZ),
        tone_half_period(4'd5, CLK_HZ), tone_half_period(4'd6, CLK_HZ),
        tone_half_period(4'd7, CLK_HZ), tone_half_period(4'd8, CLK_HZ)
    };

    logic [16:0] half;
    logic [16:0] div_q;
    logic        tog_q;
    logic        audible;

    always_comb begin
        audible = is_tone(code);
        half    = HALF_TAB[3'(code - 4'd1)];
    end

    always_ff @(posedge clk) begin
        if (reset || restart || !audible) begin
            div_q <= '0;
            tog_q <= 1'b0;
        end else if (div_q == half - 17'd1) begin
            div_q <= '0;
            tog_q <= ~tog_q;
        end else begin
            div_q <= div_q + 17'd1;
        end
    end

    // Gating by code keeps the pin low the very cycle playback goes silent.
    assign piezo = tog_q & audible & ~restart;

endmodule

// File: rtl/melody_sequencer.sv
// Plays up to eight latched 4-bit note codes with fixed note and gap timing,
// using a start/busy/done handshake toward the game FSM.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned NOTE_TICKS = 5_000_000,
    parameter int unsigned GAP_TICKS  = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] pattern,
    input  logic [3:0]  length,
    output logic        busy,
    output logic        done,
    output logic [2:0]  note_idx,
    output logic [3:0]  note_out,
    output logic        piezo
);

    localparam int unsigned MaxTicks = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam logic [TickW-1:0] NoteLast = TickW'(NOTE_TICKS - 1);
    localparam logic [TickW-1:0] GapLast  = TickW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

    state_e           state_q;
    logic [TickW-1:0] tick_q;
    logic [31:0]      pat_q;
    logic [3:0]       len_q;
    logic             restart_q;
    logic [3:0]       len_clamped;
    logic             last_note;
    logic [2:0]       next_idx;

    always_comb begin
        len_clamped = clamp_length(length);
        last_note   = ({1'b0, note_idx} + 4'd1) == len_q;
        next_idx    = note_idx + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            restart_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
            note_out  <= '0;
        end else begin
            done      <= 1'b0;
            restart_q <= 1'b0;
            if (stop) begin
                state_q  <= StIdle;
                tick_q   <= '0;
                busy     <= 1'b0;
                note_idx <= '0;
                note_out <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            pat_q    <= pattern;
                            len_q    <= len_clamped;
                            note_idx <= '0;
                            tick_q   <= '0;
                            if (len_clamped == 4'd0) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else begin
                                state_q   <= StNote;
                                busy      <= 1'b1;
                                note_out  <= pattern[3:0];
                                restart_q <= 1'b1;
                            end
                        end
                    end
                    StNote: begin
                        if (tick_q == NoteLast) begin
                            tick_q <= '0;
                            if (last_note) begin
                                state_q  <= StDone;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                note_out <= '0;
                            end else if (GAP_TICKS > 0) begin
                                state_q  <= StGap;
                                note_out <= '0;
                            end else begin
                                note_idx  <= next_idx;
                                note_out  <= note_code(pat_q, next_idx);
                                restart_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    StGap: begin
                        if (tick_q == GapLast) begin
                            tick_q    <= '0;
                            state_q   <= StNote;
                            note_idx  <= next_idx;
                            note_out  <= note_code(pat_q, next_idx);
                            restart_q <= 1'b1;
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    tone_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tone (
        .clk    (clk),
        .reset  (reset),
        .restart(restart_q),
        .code   (note_out),
        .piezo  (piezo)
    );

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed note/done events and probes,
// a monitor compares them against two sequencer instances.
module tb_melody_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset = 1'b1;
    logic        start1 = 1'b0, stop1 = 1'b0;
    logic [31:0] pattern1 = '0;
    logic [3:0]  length1 = '0;
    logic        busy1, done1, piezo1;
    logic [2:0]  note_idx1;
    logic [3:0]  note_out1;

    logic        start2 = 1'b0, stop2 = 1'b0;
    logic [31:0] pattern2 = '0;
    logic [3:0]  length2 = '0;
    logic        busy2, done2, piezo2;
    logic [2:0]  note_idx2;
    logic [3:0]  note_out2;

    // Small clock so code halves are 4,4,3,3,3,2,2,2 cycles and toggle inside a note.
    melody_sequencer #(.CLK_HZ(2500), .NOTE_TICKS(10), .GAP_TICKS(2)) u_seq1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1), .pattern(pattern1),
        .length(length1), .busy(busy1), .done(done1), .note_idx(note_idx1),
        .note_out(note_out1), .piezo(piezo1)
    );

    // Code 1 half-period 95 cycles, code 2 85 cycles; no gap between notes.
    melody_sequencer #(.CLK_HZ(50_000), .NOTE_TICKS(400), .GAP_TICKS(0)) u_seq2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .pattern(pattern2),
        .length(length2), .busy(busy2), .done(done2), .note_idx(note_idx2),
        .note_out(note_out2), .piezo(piezo2)
    );

    localparam int KNote = 0, KDone = 1;
    localparam int SBusy = 0, SDone = 1, SIdx = 2, SOut = 3, SPiezo = 4;

    typedef struct {int cyc; int kind; int val;} ev_t;
    typedef struct {int cyc; int sig; int val;} probe_t;

    ev_t    evq1[$];
    ev_t    evq2[$];
    probe_t pq[$];
    bit     fin_req = 1'b0;
    int     checks = 0;
    int     errors = 0;

    function automatic bit audible(input logic [3:0] c);
        return c >= 4'd1 && c <= 4'd8;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic ev_seen(input int which, input int kind, input int val);
        ev_t e;
        checks++;
        if ((which == 1 && evq1.size() == 0) || (which == 2 && evq2.size() == 0)) begin
            errors++;
            $display("FAIL u%0d_event at cycle %0d: got kind %0d val %0d, expected none",
                     which, cyc, kind, val);
            return;
        end
        if (which == 1) e = evq1.pop_front();
        else e = evq2.pop_front();
        if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            errors++;
            $display("FAIL u%0d_event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                     which, kind, val, cyc, e.kind, e.val, e.cyc);
        end
    endtask

    task automatic exp1(input int c, input int k, input int v);
        evq1.push_back('{c, k, v});
    endtask

    task automatic probe(input int c, input int s, input int v);
        pq.push_back('{c, s, v});
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: owns every comparison and the counters.
    initial begin
        logic [3:0] prev1 = '0, prev2 = '0;
        logic       prev_pz2 = 1'b0;
        int         slot_start = 0, last_edge2 = -1, got;
        bit         hi_seen = 1'b0;
        probe_t     p;
        forever begin
            @(negedge clk);
            if (fin_req) begin
                check("u1_events_left", evq1.size(), 0);
                check("u2_events_left", evq2.size(), 0);
                check("probes_left", pq.size(), 0);
                check("u2_idle_busy", int'(busy2), 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (cyc >= 1) begin
                if (note_out1 !== prev1) begin
                    if (audible(prev1) && (cyc - slot_start) == 10)
                        check("u1_tone_active", int'(hi_seen), 1);
                    ev_seen(1, KNote, int'(note_out1));
                    prev1      = note_out1;
                    slot_start = cyc;
                    hi_seen    = 1'b0;
                end
                if (done1 === 1'b1) ev_seen(1, KDone, 0);
                hi_seen = hi_seen | piezo1;
                if (!audible(note_out1)) check("u1_piezo_silent", int'(piezo1), 0);

                if (note_out2 !== prev2) begin
                    ev_seen(2, KNote, int'(note_out2));
                    prev2      = note_out2;
                    last_edge2 = -1;
                end else if (piezo2 !== prev_pz2 && audible(note_out2)) begin
                    if (last_edge2 >= 0 && note_out2 == 4'd1)
                        check("u2_half_c4", cyc - last_edge2, 95);
                    if (last_edge2 >= 0 && note_out2 == 4'd2)
                        check("u2_half_d4", cyc - last_edge2, 85);
                    last_edge2 = cyc;
                end
                prev_pz2 = piezo2;
                if (done2 === 1'b1) ev_seen(2, KDone, 0);
                if (!audible(note_out2)) check("u2_piezo_silent", int'(piezo2), 0);

                while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                    p = pq.pop_front();
                    case (p.sig)
                        SBusy:   got = int'(busy1);
                        SDone:   got = int'(done1);
                        SIdx:    got = int'(note_idx1);
                        SOut:    got = int'(note_out1);
                        default: got = int'(piezo1);
                    endcase
                    if (p.cyc != cyc) check("probe_time", cyc, p.cyc);
                    else check($sformatf("probe_sig%0d", p.sig), got, p.val);
                end
            end
        end
    end

    // Stimulus: every expectation is queued up front, then inputs follow the schedule.
    initial begin
        // Reset state
        probe(3, SBusy, 0); probe(3, SDone, 0); probe(3, SIdx, 0);
        probe(3, SOut, 0); probe(3, SPiezo, 0);
        // Normal playback, with an ignored start and pattern change at 20
        exp1(6, KNote, 1); exp1(16, KNote, 0); exp1(18, KNote, 2); exp1(28, KNote, 0);
        exp1(30, KNote, 3); exp1(40, KNote, 0); exp1(40, KDone, 0);
        probe(5, SBusy, 0); probe(6, SBusy, 1); probe(6, SIdx, 0); probe(16, SIdx, 0);
        probe(18, SIdx, 1); probe(30, SIdx, 2); probe(39, SBusy, 1);
        probe(40, SBusy, 0); probe(40, SDone, 1); probe(41, SDone, 0);
        // Zero length
        exp1(42, KDone, 0);
        probe(42, SBusy, 0); probe(42, SDone, 1); probe(43, SDone, 0);
        // Length 12 clamps to 8 notes
        for (int k = 0; k < 8; k++) begin
            exp1(46 + 12 * k, KNote, k + 1);
            exp1(56 + 12 * k, KNote, 0);
        end
        exp1(140, KDone, 0);
        // Abort in the second note, stop beating start, then replay from note 0
        exp1(146, KNote, 1); exp1(156, KNote, 0); exp1(158, KNote, 2); exp1(163, KNote, 0);
        probe(163, SBusy, 0); probe(163, SOut, 0); probe(163, SPiezo, 0); probe(163, SIdx, 0);
        probe(167, SBusy, 0); probe(167, SOut, 0);
        exp1(171, KNote, 1); exp1(181, KNote, 0); exp1(183, KNote, 2); exp1(193, KNote, 0);
        exp1(195, KNote, 3); exp1(205, KNote, 0); exp1(205, KDone, 0);
        probe(171, SIdx, 0); probe(171, SBusy, 1);
        // Rest codes 0 and 9
        exp1(211, KNote, 1); exp1(221, KNote, 0); exp1(235, KNote, 9); exp1(245, KNote, 0);
        exp1(245, KDone, 0);
        probe(223, SIdx, 1); probe(245, SDone, 1);
        // Reset mid-note
        exp1(251, KNote, 1); exp1(258, KNote, 0);
        probe(257, SBusy, 1);
        probe(258, SBusy, 0); probe(258, SDone, 0); probe(258, SIdx, 0);
        probe(258, SOut, 0); probe(258, SPiezo, 0);
        // Back-to-back notes and tone periods on the second instance
        evq2.push_back('{311, KNote, 1});
        evq2.push_back('{711, KNote, 2});
        evq2.push_back('{1111, KNote, 0});
        evq2.push_back('{1111, KDone, 0});

        at_cycle(2);   reset = 1'b0;
        at_cycle(5);   pattern1 = 32'h0000_0321; length1 = 4'd3; start1 = 1'b1;
        at_cycle(6);   start1 = 1'b0;
        at_cycle(20);  pattern1 = 32'h0000_0888; start1 = 1'b1;
        at_cycle(21);  start1 = 1'b0;
        at_cycle(41);  length1 = 4'd0; start1 = 1'b1;
        at_cycle(42);  start1 = 1'b0;
        at_cycle(45);  pattern1 = 32'h8765_4321; length1 = 4'd12; start1 = 1'b1;
        at_cycle(46);  start1 = 1'b0;
        at_cycle(145); pattern1 = 32'h0000_0321; length1 = 4'd3; start1 = 1'b1;
        at_cycle(146); start1 = 1'b0;
        at_cycle(162); stop1 = 1'b1;
        at_cycle(163); stop1 = 1'b0;
        at_cycle(166); stop1 = 1'b1; start1 = 1'b1;
        at_cycle(167); stop1 = 1'b0; start1 = 1'b0;
        at_cycle(170); start1 = 1'b1;
        at_cycle(171); start1 = 1'b0;
        at_cycle(210); pattern1 = 32'h0000_0901; start1 = 1'b1;
        at_cycle(211); start1 = 1'b0;
        at_cycle(250); pattern1 = 32'h0000_0321; start1 = 1'b1;
        at_cycle(251); start1 = 1'b0;
        at_cycle(257); reset = 1'b1;
        at_cycle(258); reset = 1'b0;
        at_cycle(310); pattern2 = 32'h0000_0021; length2 = 4'd2; start2 = 1'b1;
        at_cycle(311); start2 = 1'b0;
        at_cycle(1130);
        fin_req = 1'b1;
    end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Playback controller for the stored answer pattern in the memory game. On a `start` pulse it latches a 32-bit pattern of eight 4-bit note codes and plays the first `length` notes in order. Each note sounds for a fixed note time, followed by a fixed silent gap. A `done` pulse signals completion to the game FSM. It sits between the answer register (pattern source) and the piezo pin, replacing free-running tick-driven playback with an explicit start/busy/done handshake.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; used by the package to derive tone dividers.
- `NOTE_TICKS`, 5_000_000, clock cycles per sounding note (0.1 s); must be ≥1.
- `GAP_TICKS`, 500_000, silent cycles between consecutive notes; 0 means no gap.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `start` in 1: single-cycle request to begin playback; ignored while `busy`.
- `stop` in 1: abort playback; takes priority over `start`.
- `pattern` in 32: note codes; note i = `pattern[4i+3:4i]`, i=0 played first.
- `length` in 4: number of notes to play; values >8 clamp to 8; 0 means no notes.
- `busy` out 1: high from the cycle after an accepted `start` until playback ends.
- `done` out 1: one-cycle pulse on normal completion only.
- `note_idx` out 3: index of the note currently in NOTE/GAP.
- `note_out` out 4: code of the sounding note; 0 during GAP/IDLE.
- `piezo` out 1: square wave for the current note; low when silent.

## Operation
- States: IDLE, NOTE, GAP, DONE.
- IDLE: `start` (and not `stop`) latches `pattern` and the clamped `length`, clears `note_idx` and the tick counter.
  - If clamped length = 0, go to DONE.
  - Otherwise go to NOTE.
- NOTE: tick counter runs 0..NOTE_TICKS-1.
  - At the last tick, if this is the last note, go to DONE.
  - Else, if GAP_TICKS>0, go to GAP.
  - Else increment `note_idx` and stay in NOTE with the counter reset.
- GAP: counter runs 0..GAP_TICKS-1; at the last tick, increment `note_idx` and go to NOTE.
- DONE: assert `done` for exactly one cycle, then go to IDLE.
- `stop` in any state forces IDLE next cycle. No `done` pulse; `piezo` low from the next cycle.
- `start` while busy is ignored. Pattern changes after latch do not affect playback.
- Note codes: 0 = rest (`piezo` low, but the slot is still timed as a note); 1..8 = C4,D4,E4,F4,G4,A4,B4,C5; 9..15 = rest.
- Tone generation: half-period counter is reloaded from the divider table on every NOTE entry, and `piezo` starts low. `piezo` toggles each time the counter reaches half-period−1.
- Counters: tick counter is `$clog2(max(NOTE_TICKS,GAP_TICKS))` bits wide; divider counter is 17 bits. No wrap beyond terminal values.

## Timing
- Reset values: `busy`=0, `done`=0, `note_idx`=0, `note_out`=0, `piezo`=0; state is IDLE.
- `start` at cycle t → state NOTE and `busy`=1 at t+1. `note_out` is valid at t+1.
- Start-to-`done` latency is L·NOTE_TICKS + (L−1)·GAP_TICKS + 1 cycles, where L = clamped length ≥1. L=0 gives `done` at t+1.
- `busy`=0 in the DONE cycle. A new `start` is accepted in the cycle after `done`.
- `stop` and `start` in the same cycle: `stop` wins.
- `reset` mid-playback behaves like `stop` and also clears all outputs.

## Structure
- Package `melody_pkg`:
  - state encoding constants.
  - `function tone_half_period(code)` returning CLK_HZ/(2·f). At 50 MHz: 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
  - `MAX_NOTES`=8.
- Sub-module `tone_gen`: inputs are `clk`, `reset`, `restart`, and a 4-bit `code`; output is `piezo`. It holds the divider counter and toggle flop.

## Test plan
- Normal playback: NOTE_TICKS=10, GAP_TICKS=2, `pattern`=32'h00000321, `length`=3, `start` at t=5.
  - `note_out` is 1, 2, 3 at t=6, 18, 30 and 0 in the gaps.
  - `done` pulses at t=40; `busy` is high from t=6 to t=39.
- Zero length: `length`=0 → `done` at t+1, `piezo` never toggles. `length`=12 → 8 notes play.
- Abort: `stop` asserted during the 2nd note → IDLE next cycle, no `done`, `piezo`=0.
  - A following `start` replays from note 0.
- Ignored start: `start` pulsed while busy, and `pattern` changed mid-play → original sequence and timing unchanged.
- Rest code and no gap: code 0 or 9 → `piezo` constant low for NOTE_TICKS. GAP_TICKS=0 → notes back-to-back.
- Tone and reset: with CLK_HZ set small, the code 1 half-period matches the package value, measured between `piezo` edges.
  - `reset` mid-note clears all outputs the next cycle.
